uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port baud_tick, input, 1 bit: one-cycle pulse, one per bit period.
REQ-006 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-007 SHALL have port stop2, input, 1 bit: 1 = two stop bits, 0 = one stop bit.
REQ-008 SHALL have port in_valid, input, 1 bit: write request.
REQ-009 SHALL have port in_data, input, DATA_BITS bits: byte to send.
REQ-010 SHALL have port in_ready, output, 1 bit: FIFO not full.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1 bit: frame in progress.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

Function
REQ-015 SHALL accept a word into the FIFO on any cycle where in_valid and in_ready are both 1; in_ready = (fifo_level != FIFO_DEPTH).
REQ-016 SHALL ignore in_valid while in_ready is 0; no overwrite, no error flag.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, advancing only on baud_tick.
REQ-018 SHALL, in IDLE on a baud_tick with the FIFO non-empty at that cycle, pop one word, latch parity_mode/stop2, drive tx=0 and enter START, all registered on that edge.
REQ-019 SHALL shift data LSB first, one bit per baud_tick, DATA_BITS bits, using a bit counter.
REQ-020 SHALL send PARITY only if the latched mode is even or odd: even = XOR of data bits, odd = its inverse.
REQ-021 SHALL drive tx=1 in STOP1, and in STOP2 only if stop2 was latched as 1.
REQ-022 SHALL, on the baud_tick ending the last stop bit, pulse frame_done for one cycle, then:
  - if the FIFO is non-empty, start the next frame on that same tick (back-to-back, no idle bit);
  - otherwise go to IDLE.
REQ-023 SHALL ignore parity_mode/stop2 changes mid-frame; they take effect at the next frame start.
REQ-024 SHALL assert tx_busy in every state except IDLE.
REQ-025 SHALL, on a simultaneous push and pop, update fifo_level by net 0; a push into an empty FIFO is poppable no earlier than the following cycle.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL ignore baud_tick in IDLE with an empty FIFO; tx stays 1.

Reset
REQ-028 SHALL, on rst, force:
  - tx=1, tx_busy=0, frame_done=0, in_ready=1, fifo_level=0;
  - FSM to IDLE and pointers to 0, discarding FIFO contents and any frame in flight.
REQ-029 SHALL resume normal operation on the first clk edge after rst deasserts.

Structure
REQ-030 SHALL take the parity-mode enum and FSM state enum from shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module, uart_sync_fifo (parameters WIDTH, DEPTH), for buffering; framing logic stays in uart_tx_cfg.

Verification
REQ-032 SHALL check 8N1, in_data=0xA5, periodic ticks -> tx bits per tick 0,1,0,1,0,0,1,0,1,1; frame_done once.
REQ-033 SHALL check 8E2 with 0xA5 -> parity bit 0 and two stop bits; 8O1 with 0xA5 -> parity bit 1.
REQ-034 SHALL check a burst write of FIFO_DEPTH+2 words with no ticks -> in_ready low after 8 words; the last 2 are dropped; fifo_level=8.
REQ-035 SHALL check three queued words -> three contiguous frames, no idle bits between them, tx_busy continuously high.
REQ-036 SHALL check rst asserted mid-DATA -> tx=1, tx_busy=0, fifo_level=0 immediately; no further frame starts.
REQ-037 SHALL check parity_mode changed mid-frame -> current frame unchanged; the next frame uses the new mode.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity-mode and transmitter state enums, plus parity helpers.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  function automatic logic parity_used(parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Zero-extension of narrower words leaves the XOR unchanged.
  function automatic logic parity_bit(parity_e mode, logic [MAX_DATA_BITS-1:0] data);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap naturally at a power-of-two depth.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Requests against a full (push) or empty (pop) FIFO are silently dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with buffered input and per-frame parity / stop-bit configuration.
module uart_tx_cfg import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tx_q, tx_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop2_q, stop2_d;
  logic                   done_q, done_d;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   load_frame, end_frame;
  parity_e                mode_in;

  // Write handshake: a word is taken on every clk edge where in_valid && in_ready;
  // in_valid while in_ready is low is ignored and in_data need not be held.
  assign in_ready = !fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign mode_in    = parity_e'(parity_mode);
  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = done_q;

  // tx_q always holds the level of the bit period that begins on the current tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;
    end_frame  = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: load_frame = !fifo_empty;
        START: begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + CW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
        STOP1: begin
          if (stop2_q) begin
            state_d = STOP2;
            tx_d    = 1'b1;
          end else begin
            end_frame = 1'b1;
          end
        end
        STOP2: end_frame = 1'b1;
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    // The tick closing a frame may open the next one directly, with no idle bit.
    if (end_frame) begin
      done_d     = 1'b1;
      state_d    = IDLE;
      tx_d       = 1'b1;
      load_frame = !fifo_empty;
    end

    if (load_frame) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      par_en_d  = parity_used(mode_in);
      par_bit_d = parity_bit(mode_in, MAX_DATA_BITS'(fifo_rdata));
      stop2_d   = stop2;
      tx_d      = 1'b0;
      state_d   = START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      tx_q      <= 1'b1;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frame-list reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_cfg;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          baud_tick = 1'b0;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, tx, tx_busy, frame_done;
  logic [LW-1:0] fifo_level;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   tdiv = 0;
  int   n = 0;
  int   busy_cycles = 0;
  logic tick_en = 1'b0;
  logic [15:0] got;

  // Reference model: words waiting in the FIFO and the bits still to be sent in the current frame.
  logic [DW-1:0] exp_q[$];
  logic          bit_q[$];
  logic          exp_done = 1'b0;
  logic          m_room;
  logic [DW-1:0] m_w;
  logic          tx_log[$];

  uart_tx_cfg #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .fifo_level  (fifo_level)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (tick_en) begin
      tdiv      = (tdiv == 3) ? 0 : tdiv + 1;
      baud_tick = (tdiv == 3);
    end else begin
      tdiv      = 0;
      baud_tick = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      bit_q.delete();
      exp_done = 1'b0;
    end else begin
      m_room   = (exp_q.size() < DEPTH);
      exp_done = 1'b0;
      if (baud_tick) begin
        if (bit_q.size() > 0) begin
          void'(bit_q.pop_front());
          if (bit_q.size() == 0) exp_done = 1'b1;
        end
        if (bit_q.size() == 0 && exp_q.size() > 0) begin
          m_w = exp_q.pop_front();
          bit_q.push_back(1'b0);
          for (int i = 0; i < DW; i++) bit_q.push_back(m_w[i]);
          if (parity_mode == 2'b01) bit_q.push_back(^m_w);
          if (parity_mode == 2'b10) bit_q.push_back(~^m_w);
          bit_q.push_back(1'b1);
          if (stop2) bit_q.push_back(1'b1);
        end
      end
      if (in_valid && m_room) exp_q.push_back(in_data);
    end
  end

  function automatic logic exp_tx();
    return (bit_q.size() > 0) ? bit_q[0] : 1'b1;
  endfunction

  // tx level right after each tick, for literal bit-pattern checks.
  always @(posedge clk) begin
    if (baud_tick && !rst) begin
      #1;
      tx_log.push_back(tx);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got_v, exp_v, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    check("tx", tx, exp_tx());
    check("tx_busy", tx_busy, bit_q.size() > 0);
    check("fifo_level", fifo_level, exp_q.size());
    check("in_ready", in_ready, exp_q.size() < DEPTH);
    check("frame_done", frame_done, exp_done);
    if (frame_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic push_words(input int cnt, input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [DW-1:0] d;
    d = base;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      d        = d + step;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames_done();
    int k;
    k = 0;
    while (!tx_busy && k < 200) begin
      @(negedge clk); #1; k++;
    end
    check("busy_rise", tx_busy, 1'b1);
    k = 0;
    while (tx_busy && k < 3000) begin
      @(negedge clk); #1; k++;
    end
    check("busy_fall", tx_busy, 1'b0);
  endtask

  task automatic run_single(input logic [1:0] pm, input logic s2, input logic [DW-1:0] w,
                            output logic [15:0] bits);
    parity_mode = pm;
    stop2       = s2;
    tx_log.delete();
    done_cnt    = 0;
    push_words(1, w, '0);
    tick_en = 1'b1;
    wait_frames_done();
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    bits = '0;
    for (int i = 0; i < 16; i++) if (i < tx_log.size()) bits[i] = tx_log[i];
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_level", fifo_level, 0);
    #2 rst = 1'b0;

    // 8N1, 8E2, 8O1 with 0xA5 (bit i = tx after tick i)
    run_single(2'b00, 1'b0, 8'hA5, got);
    check("8n1_bits", got[9:0], 10'h34A);
    check("8n1_done_cnt", done_cnt, 1);
    run_single(2'b01, 1'b1, 8'hA5, got);
    check("8e2_bits", got[11:0], 12'hD4A);
    check("8e2_parity", got[9], 1'b0);
    run_single(2'b10, 1'b0, 8'hA5, got);
    check("8o1_bits", got[10:0], 11'h74A);
    check("8o1_parity", got[9], 1'b1);

    // Burst of DEPTH+2 writes with no ticks: the last two are dropped
    parity_mode = 2'b00;
    stop2       = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      #1;
      if (i == DEPTH - 1) check("ready_at_7", in_ready, 1'b1);
      if (i == DEPTH)     check("ready_at_8", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("burst_level", fifo_level, DEPTH);
    check("burst_ready", in_ready, 1'b0);
    done_cnt = 0;
    tick_en  = 1'b1;
    wait_frames_done();
    tick_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("burst_frames", done_cnt, DEPTH);
    check("burst_drained", fifo_level, 0);

    // Three queued words: 30 contiguous bit periods of 4 cycles each
    push_words(3, 8'h11, 8'h22);
    done_cnt = 0;
    tick_en  = 1'b1;
    n = 0;
    while (!tx_busy && n < 200) begin
      @(negedge clk); #1; n++;
    end
    busy_cycles = 0;
    while (tx_busy && busy_cycles < 1000) begin
      busy_cycles++;
      @(negedge clk); #1;
    end
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_busy_cycles", busy_cycles, 120);
    check("b2b_frames", done_cnt, 3);

    // Parity mode changed mid-frame applies only to the next frame
    parity_mode = 2'b01;
    stop2       = 1'b0;
    tx_log.delete();
    push_words(2, 8'hA5, '0);
    tick_en = 1'b1;
    repeat (20) @(negedge clk);
    parity_mode = 2'b10;
    wait_frames_done();
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    check("pchg_frame1_parity", tx_log[9], 1'b0);
    check("pchg_frame2_parity", tx_log[20], 1'b1);
    check("pchg_frame2_start", tx_log[11], 1'b0);

    // Reset in the middle of the data bits
    parity_mode = 2'b00;
    tx_log.delete();
    push_words(2, 8'h5A, '0);
    tick_en = 1'b1;
    n = 0;
    while (tx_log.size() < 4 && n < 200) begin
      @(negedge clk); n++;
    end
    #1;
    check("pre_rst_busy", tx_busy, 1'b1);
    check("pre_rst_level", fifo_level, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (tx_busy) busy_cycles++;
    end
    tick_en = 1'b0;
    check("post_rst_no_frame", busy_cycles, 0);
    check("post_rst_tx_idle", tx, 1'b1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
